treasure_scan_controller: RTL and testbench
===========================================

// Module: treasure_scan_controller
// PURPOSE
//  Sequences one treasure scan per Arduino request. Samples the image processor's
//  per-frame RESULT code after each VGA frame and commits a code once it is stable
//  over STABLE_FRAMES consecutive frames, or commits 3'b000 after MAX_FRAMES frames.
//  Delivers the committed code to the Arduino over a 4-phase REQ/ACK handshake.
//  Sits between IMAGE_PROCESSOR (RESULT, VGA_VSYNC_NEG) and the Arduino GPIO pins.
// PARAMETERS
//  SAMPLE_DELAY   2          cycles from VSYNC falling edge to RESULT_IN sample (1..15)
//  STABLE_FRAMES  8          consecutive identical samples required to commit (1..255)
//  MAX_FRAMES     60         frames per scan before timeout commit of 3'b000 (1..255)
//  ACK_TIMEOUT    2500000    cycles to wait for each ACK edge before abort (24-bit)
// PORTS
//  CLK            in   1  system clock (same clock as IMAGE_PROCESSOR)
//  RESET          in   1  synchronous, active-high reset
//  VGA_VSYNC_NEG  in   1  VGA vsync, active low; its falling edge ends a frame
//  RESULT_IN      in   3  IMAGE_PROCESSOR RESULT code (000 = none)
//  SCAN_REQ       in   1  Arduino scan request, level; sampled only in IDLE
//  ARD_ACK        in   1  Arduino acknowledge (4-phase)
//  ARD_REQ        out  1  data-valid request to Arduino
//  ARD_DATA       out  3  committed code; stable whenever ARD_REQ=1
//  BUSY           out  1  1 in every state except IDLE
//  TIMEOUT        out  1  1 if the last commit came from MAX_FRAMES expiry
//  ACK_ERR        out  1  one-cycle pulse when a handshake is aborted
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; counters 0; vsync_prev=0.
//  vsync_fall = vsync_prev & ~VGA_VSYNC_NEG; vsync_prev registers every cycle.
//  States:
//  IDLE: if SCAN_REQ=1 then frame_cnt=0, match_cnt=0, last=3'b000, TIMEOUT=0, go ARMED.
//  ARMED: on vsync_fall, load dly=SAMPLE_DELAY and go DELAY. Other cycles: hold.
//  DELAY: decrement dly. When dly reaches 0, sample=RESULT_IN and go EVAL.
//    Sample is taken exactly SAMPLE_DELAY cycles after the vsync_fall cycle.
//  EVAL (1 cycle): frame_cnt+=1.
//    If sample==last: match_cnt+=1 (saturating); else match_cnt=1, last=sample.
//    A first sample of 000 matches the reset last=000.
//    If match_cnt(new)>=STABLE_FRAMES: commit sample, go SEND.
//    Else if frame_cnt(new)>=MAX_FRAMES: commit 3'b000, TIMEOUT=1, go SEND.
//    Else go ARMED. The stable check has priority when both hold in the same frame.
//  SEND: ARD_DATA=commit and ARD_REQ=1, both registered on entry.
//    ARD_ACK=1 -> ARD_REQ=0, go RELEASE.
//    ACK wait counter reaches ACK_TIMEOUT -> ARD_REQ=0, ACK_ERR pulse, go IDLE.
//  RELEASE: ARD_ACK=0 -> go IDLE. Timeout -> ACK_ERR pulse, go IDLE.
//  ACK wait counter clears on entry to SEND and to RELEASE.
//  ARD_DATA holds its last value after the handshake and only changes on a new commit.
//  SCAN_REQ is ignored outside IDLE.
//  If SCAN_REQ is still high on return to IDLE, a new scan starts the next cycle.
//  vsync_fall seen in DELAY, EVAL, SEND or RELEASE is ignored: at most one sample per frame.
//  RESET in any state aborts the scan on the next edge. ARD_REQ drops to 0.
//  Latency: stable object = STABLE_FRAMES frames + SAMPLE_DELAY + 2 cycles to ARD_REQ.
// TESTING
//  1. RESULT_IN=010 constant, SCAN_REQ pulse, 8 frames.
//     -> ARD_REQ rises SAMPLE_DELAY+2 cycles after the 8th vsync fall.
//     -> ARD_DATA=010, TIMEOUT=0.
//  2. RESULT_IN alternates 001/101 every frame -> after frame 60: ARD_DATA=000, TIMEOUT=1.
//  3. Sequence 101 x5, 011 x1, 101 x8 -> commit 101 on frame 14 (match count restarts).
//  4. ARD_ACK never asserted -> ARD_REQ falls and ACK_ERR pulses once after ACK_TIMEOUT
//     cycles; BUSY=0.
//  5. RESET asserted mid-DELAY and mid-SEND -> next cycle all outputs 0, state IDLE;
//     a fresh scan then works normally.
//  6. SCAN_REQ held high across a full handshake -> second scan begins one cycle
//     after RELEASE exits.

Source files
------------

// File: rtl/treasure_scan_controller.sv
// treasure_scan_controller
// Runs one treasure scan for each Arduino request. After every VGA frame it samples
// the image processor's RESULT code. A code is committed once it has been seen on
// STABLE_FRAMES consecutive frames. If MAX_FRAMES frames pass first, 3'b000 is
// committed instead. The committed code is then handed to the Arduino over a
// 4-phase REQ/ACK handshake.
//
// Handshake: ARD_REQ rises with ARD_DATA already valid. ARD_DATA stays stable for
// as long as ARD_REQ=1. The Arduino raises ARD_ACK once it has taken the data, and
// ARD_REQ then drops. The controller waits for ARD_ACK to return low before it goes
// idle again. Each of the two ACK edges has ACK_TIMEOUT cycles to arrive. If it does
// not, the transfer is abandoned and ACK_ERR pulses for one cycle.
module treasure_scan_controller #(
  parameter int SAMPLE_DELAY  = 2,
  parameter int STABLE_FRAMES = 8,
  parameter int MAX_FRAMES    = 60,
  parameter int ACK_TIMEOUT   = 2500000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VGA_VSYNC_NEG,
  input  logic [2:0] RESULT_IN,
  input  logic       SCAN_REQ,
  input  logic       ARD_ACK,
  output logic       ARD_REQ,
  output logic [2:0] ARD_DATA,
  output logic       BUSY,
  output logic       TIMEOUT,
  output logic       ACK_ERR,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_EVAL    = 3'd3,
    S_SEND    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam logic [3:0]  DLY_LOAD   = 4'(SAMPLE_DELAY);
  localparam logic [7:0]  STABLE_LIM = 8'(STABLE_FRAMES);
  localparam logic [7:0]  FRAME_LIM  = 8'(MAX_FRAMES);
  localparam logic [23:0] ACK_LAST   = 24'(ACK_TIMEOUT - 1);

  state_t      state, state_next;
  logic        vsync_prev;
  logic        vsync_fall;
  logic [3:0]  dly;
  logic [2:0]  sample;
  logic [2:0]  last;
  logic [7:0]  frame_cnt;
  logic [7:0]  match_cnt;
  logic [23:0] ack_cnt;

  logic [7:0]  match_next;
  logic [7:0]  frame_next;
  logic        stable_hit;
  logic        frames_hit;
  logic        ack_expired;

  assign vsync_fall = vsync_prev & ~VGA_VSYNC_NEG;
  assign BUSY       = (state != S_IDLE);
  assign dbg_state  = state;

  // Per-frame evaluation terms: the new match/frame counts and the two commit conditions
  always_comb begin
    match_next = 8'd1;
    if (sample == last) begin
      match_next = (match_cnt == 8'hFF) ? match_cnt : match_cnt + 8'd1;
    end
    frame_next  = frame_cnt + 8'd1;
    stable_hit  = (match_next >= STABLE_LIM);
    frames_hit  = (frame_next >= FRAME_LIM);
    ack_expired = (ack_cnt == ACK_LAST);
  end

  // Next-state logic for the scan sequencer
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (SCAN_REQ) state_next = S_ARMED;
      S_ARMED:   if (vsync_fall) state_next = S_DELAY;
      S_DELAY:   if (dly <= 4'd1) state_next = S_EVAL;
      S_EVAL:    state_next = (stable_hit || frames_hit) ? S_SEND : S_ARMED;
      S_SEND: begin
        if (ARD_ACK) state_next = S_RELEASE;
        else if (ack_expired) state_next = S_IDLE;
      end
      S_RELEASE: if (!ARD_ACK || ack_expired) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State register, scan counters, committed code and handshake outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      vsync_prev <= 1'b0;
      dly        <= 4'd0;
      sample     <= 3'b000;
      last       <= 3'b000;
      frame_cnt  <= 8'd0;
      match_cnt  <= 8'd0;
      ack_cnt    <= 24'd0;
      ARD_REQ    <= 1'b0;
      ARD_DATA   <= 3'b000;
      TIMEOUT    <= 1'b0;
      ACK_ERR    <= 1'b0;
    end else begin
      state      <= state_next;
      vsync_prev <= VGA_VSYNC_NEG;
      ACK_ERR    <= 1'b0;

      // The ACK wait counter restarts whenever SEND or RELEASE is entered
      if ((state_next == S_SEND || state_next == S_RELEASE) && state_next == state) begin
        ack_cnt <= ack_cnt + 24'd1;
      end else begin
        ack_cnt <= 24'd0;
      end

      case (state)
        S_IDLE: begin
          if (SCAN_REQ) begin
            frame_cnt <= 8'd0;
            match_cnt <= 8'd0;
            last      <= 3'b000;
            TIMEOUT   <= 1'b0;
          end
        end
        S_ARMED: begin
          if (vsync_fall) dly <= DLY_LOAD;
        end
        S_DELAY: begin
          if (dly <= 4'd1) begin
            dly    <= 4'd0;
            sample <= RESULT_IN;
          end else begin
            dly <= dly - 4'd1;
          end
        end
        S_EVAL: begin
          frame_cnt <= frame_next;
          match_cnt <= match_next;
          last      <= sample;
          // When both limits are hit in the same frame, the stable code wins
          if (stable_hit) begin
            ARD_DATA <= sample;
            ARD_REQ  <= 1'b1;
          end else if (frames_hit) begin
            ARD_DATA <= 3'b000;
            TIMEOUT  <= 1'b1;
            ARD_REQ  <= 1'b1;
          end
        end
        S_SEND: begin
          if (ARD_ACK) begin
            ARD_REQ <= 1'b0;
          end else if (ack_expired) begin
            ARD_REQ <= 1'b0;
            ACK_ERR <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (ARD_ACK && ack_expired) ACK_ERR <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_treasure_scan_controller.sv
// Directed bench for treasure_scan_controller. It uses a short ACK_TIMEOUT so that
// the abort path can be reached quickly.
module tb_treasure_scan_controller;

  localparam int ACK_TO = 40;

  logic       CLK;
  logic       RESET;
  logic       VGA_VSYNC_NEG;
  logic [2:0] RESULT_IN;
  logic       SCAN_REQ;
  logic       ARD_ACK;
  logic       ARD_REQ;
  logic [2:0] ARD_DATA;
  logic       BUSY;
  logic       TIMEOUT;
  logic       ACK_ERR;
  logic [2:0] dbg_state;

  int tests_run;
  int tests_failed;

  treasure_scan_controller #(
    .SAMPLE_DELAY(2),
    .STABLE_FRAMES(8),
    .MAX_FRAMES(60),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
    .RESULT_IN(RESULT_IN),
    .SCAN_REQ(SCAN_REQ),
    .ARD_ACK(ARD_ACK),
    .ARD_REQ(ARD_REQ),
    .ARD_DATA(ARD_DATA),
    .BUSY(BUSY),
    .TIMEOUT(TIMEOUT),
    .ACK_ERR(ACK_ERR),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
  task step();
    @(posedge CLK);
    #1;
  endtask

  task start_scan();
    SCAN_REQ = 1'b1;
    step();
    SCAN_REQ = 1'b0;
  endtask

  // Frame up to and including the vsync falling edge; the fall cycle is the current one
  task frame_fall(input logic [2:0] r);
    RESULT_IN = r;
    VGA_VSYNC_NEG = 1'b1;
    repeat (6) step();
    VGA_VSYNC_NEG = 1'b0;
  endtask

  task drive_frame(input logic [2:0] r);
    frame_fall(r);
    repeat (6) step();
  endtask

  task ack_cycle();
    ARD_ACK = 1'b1;
    step();
    ARD_ACK = 1'b0;
    step();
  endtask

  task test_reset();
    RESET = 1'b1;
    repeat (3) step();
    tests_run++;
    if ({ARD_REQ, ARD_DATA, BUSY, TIMEOUT, ACK_ERR} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0000000", {ARD_REQ, ARD_DATA, BUSY, TIMEOUT, ACK_ERR});
    end
    tests_run++;
    if (dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    RESET = 1'b0;
    step();
  endtask

  task test_stable_commit();
    start_scan();
    tests_run++;
    if (BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL t1_busy: got %b expected 1", BUSY);
    end
    repeat (7) drive_frame(3'b010);
    frame_fall(3'b010);
    repeat (3) step();
    tests_run++;
    if (ARD_REQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL t1_req_early: got %b expected 0", ARD_REQ);
    end
    step();
    tests_run++;
    if (ARD_REQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL t1_req_rise: got %b expected 1", ARD_REQ);
    end
    tests_run++;
    if (ARD_DATA !== 3'b010 || TIMEOUT !== 1'b0) begin
      tests_failed++;
      $display("FAIL t1_data: got data=%b timeout=%b expected data=010 timeout=0", ARD_DATA, TIMEOUT);
    end
    ARD_ACK = 1'b1;
    step();
    tests_run++;
    if (ARD_REQ !== 1'b0 || BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL t1_ack: got req=%b busy=%b expected req=0 busy=1", ARD_REQ, BUSY);
    end
    ARD_ACK = 1'b0;
    step();
    tests_run++;
    if (BUSY !== 1'b0 || ARD_DATA !== 3'b010) begin
      tests_failed++;
      $display("FAIL t1_release: got busy=%b data=%b expected busy=0 data=010", BUSY, ARD_DATA);
    end
  endtask

  task test_frame_timeout();
    start_scan();
    for (int i = 0; i < 59; i++) drive_frame((i % 2 == 0) ? 3'b001 : 3'b101);
    tests_run++;
    if (ARD_REQ !== 1'b0 || BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL t2_frame59: got req=%b busy=%b expected req=0 busy=1", ARD_REQ, BUSY);
    end
    drive_frame(3'b101);
    tests_run++;
    if (ARD_REQ !== 1'b1 || ARD_DATA !== 3'b000 || TIMEOUT !== 1'b1) begin
      tests_failed++;
      $display("FAIL t2_timeout: got req=%b data=%b timeout=%b expected req=1 data=000 timeout=1",
               ARD_REQ, ARD_DATA, TIMEOUT);
    end
    ack_cycle();
  endtask

  task test_match_restart();
    start_scan();
    repeat (5) drive_frame(3'b101);
    drive_frame(3'b011);
    repeat (7) drive_frame(3'b101);
    tests_run++;
    if (ARD_REQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL t3_frame13: got req=%b expected 0", ARD_REQ);
    end
    drive_frame(3'b101);
    tests_run++;
    if (ARD_REQ !== 1'b1 || ARD_DATA !== 3'b101 || TIMEOUT !== 1'b0) begin
      tests_failed++;
      $display("FAIL t3_frame14: got req=%b data=%b timeout=%b expected req=1 data=101 timeout=0",
               ARD_REQ, ARD_DATA, TIMEOUT);
    end
    ack_cycle();
  endtask

  task test_ack_timeout();
    start_scan();
    repeat (7) drive_frame(3'b110);
    frame_fall(3'b110);
    repeat (4) step();
    repeat (ACK_TO - 1) step();
    tests_run++;
    if (ARD_REQ !== 1'b1 || ACK_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL t4_before_abort: got req=%b ack_err=%b expected req=1 ack_err=0", ARD_REQ, ACK_ERR);
    end
    step();
    tests_run++;
    if (ARD_REQ !== 1'b0 || ACK_ERR !== 1'b1 || BUSY !== 1'b0 || ARD_DATA !== 3'b110) begin
      tests_failed++;
      $display("FAIL t4_abort: got req=%b ack_err=%b busy=%b data=%b expected req=0 ack_err=1 busy=0 data=110",
               ARD_REQ, ACK_ERR, BUSY, ARD_DATA);
    end
    step();
    tests_run++;
    if (ACK_ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL t4_pulse_width: got %b expected 0", ACK_ERR);
    end
  endtask

  task test_reset_mid_scan();
    start_scan();
    frame_fall(3'b011);
    step();
    tests_run++;
    if (dbg_state !== 3'd2) begin
      tests_failed++;
      $display("FAIL t5_in_delay: got %0d expected 2", dbg_state);
    end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    tests_run++;
    if ({ARD_REQ, ARD_DATA, BUSY, TIMEOUT, ACK_ERR} !== 7'b0 || dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL t5_reset_delay: got outs=%b state=%0d expected outs=0000000 state=0",
               {ARD_REQ, ARD_DATA, BUSY, TIMEOUT, ACK_ERR}, dbg_state);
    end
    start_scan();
    repeat (7) drive_frame(3'b111);
    frame_fall(3'b111);
    repeat (6) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    tests_run++;
    if ({ARD_REQ, ARD_DATA, BUSY, TIMEOUT, ACK_ERR} !== 7'b0 || dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL t5_reset_send: got outs=%b state=%0d expected outs=0000000 state=0",
               {ARD_REQ, ARD_DATA, BUSY, TIMEOUT, ACK_ERR}, dbg_state);
    end
    start_scan();
    repeat (8) drive_frame(3'b100);
    tests_run++;
    if (ARD_REQ !== 1'b1 || ARD_DATA !== 3'b100) begin
      tests_failed++;
      $display("FAIL t5_fresh_scan: got req=%b data=%b expected req=1 data=100", ARD_REQ, ARD_DATA);
    end
    ack_cycle();
  endtask

  task test_back_to_back();
    SCAN_REQ = 1'b1;
    step();
    repeat (8) drive_frame(3'b001);
    tests_run++;
    if (ARD_REQ !== 1'b1 || ARD_DATA !== 3'b001) begin
      tests_failed++;
      $display("FAIL t6_first: got req=%b data=%b expected req=1 data=001", ARD_REQ, ARD_DATA);
    end
    ARD_ACK = 1'b1;
    step();
    ARD_ACK = 1'b0;
    step();
    tests_run++;
    if (BUSY !== 1'b0 || ARD_DATA !== 3'b001) begin
      tests_failed++;
      $display("FAIL t6_idle_gap: got busy=%b data=%b expected busy=0 data=001", BUSY, ARD_DATA);
    end
    step();
    tests_run++;
    if (BUSY !== 1'b1 || dbg_state !== 3'd1) begin
      tests_failed++;
      $display("FAIL t6_restart: got busy=%b state=%0d expected busy=1 state=1", BUSY, dbg_state);
    end
    SCAN_REQ = 1'b0;
    repeat (8) drive_frame(3'b010);
    tests_run++;
    if (ARD_REQ !== 1'b1 || ARD_DATA !== 3'b010) begin
      tests_failed++;
      $display("FAIL t6_second: got req=%b data=%b expected req=1 data=010", ARD_REQ, ARD_DATA);
    end
    ack_cycle();
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    RESET         = 1'b1;
    VGA_VSYNC_NEG = 1'b1;
    RESULT_IN     = 3'b000;
    SCAN_REQ      = 1'b0;
    ARD_ACK       = 1'b0;
    step();
    test_reset();
    test_stable_commit();
    test_frame_timeout();
    test_match_restart();
    test_ack_timeout();
    test_reset_mid_scan();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
